ir_cmd_scheduler: RTL and testbench
===================================

# ir_cmd_scheduler

Command controller between the NEC `ir_decoder` and downstream consumers. It validates each decoded 32-bit frame (complement checks, optional address filter) and queues accepted commands in a small FIFO. Commands are delivered over a valid/ready handshake, and NEC repeat events are re-issued as flagged copies of the last command. The block owns all policy for accepting, dropping, repeating and counting IR commands.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `ADDR_FILTER`, 0: 1 means only frames whose address equals `ADDR_MATCH` are accepted.
- `ADDR_MATCH`, 8'h00: address compared when `ADDR_FILTER`=1.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `frame_data`  in  32  decoded frame: [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd.
- `frame_valid`  in  1  one-cycle pulse qualifying `frame_data`.
- `rpt_valid`  in  1  one-cycle pulse: NEC repeat code received.
- `cmd_ready`  in  1  consumer accepts head entry.
- `cmd_valid`  out  1  FIFO non-empty.
- `cmd_addr`  out  8  head entry address.
- `cmd_code`  out  8  head entry command.
- `cmd_repeat`  out  1  head entry originated from a repeat event.
- `fifo_count`  out  $clog2(DEPTH)+1  entries held.
- `err_count`  out  8  rejected frames; saturates at 255.
- `overflow`  out  1  sticky: an entry was lost to a full FIFO.

## Operation
- FSM states: IDLE, CHECK, PUSH.
  - IDLE: `frame_valid` latches `frame_data` into a capture register, then goes to CHECK. Otherwise, `rpt_valid` (repeat enabled) with `last_ok`=1 loads the last command with rep=1, then goes to PUSH. If both pulse in the same cycle, the frame wins and the repeat is discarded.
  - CHECK: frame passes if cmd byte == ~`~cmd` byte, addr byte == ~`~addr` byte, and the address filter passes when enabled. Pass: store {addr,cmd} as last command, set `last_ok`, go to PUSH with rep=0. Fail: `err_count`+1 (saturating), clear `last_ok`, go to IDLE.
  - PUSH: write entry if not full, or if full and a pop occurs this cycle. Otherwise drop the entry and set `overflow`. Always return to IDLE.
- `frame_valid` or `rpt_valid` arriving in CHECK or PUSH is ignored. A busy-dropped `frame_valid` increments `err_count`.
- FIFO: circular buffer with wrapping read/write pointers.
  - Head is always presented on `cmd_addr`, `cmd_code` and `cmd_repeat`.
  - Pop when `cmd_valid && cmd_ready`.
  - Head outputs are don't-care when `cmd_valid`=0.
- Simultaneous push and pop: both take effect and `fifo_count` is unchanged.

## Timing
- Reset values: `cmd_valid`=0, `cmd_addr`=0, `cmd_code`=0, `cmd_repeat`=0, `fifo_count`=0, `err_count`=0, `overflow`=0. FSM returns to IDLE, `last_ok`=0, pointers cleared.
- Reset mid-operation discards the capture register and all queued entries. It takes effect the cycle after `reset` is sampled high.
- Frame latency: `frame_valid` sampled at edge N, then CHECK at N+1, then PUSH at N+2. With the FIFO empty, `cmd_valid`=1 after edge N+2. Total: 3 edges from pulse to valid.
- Repeat latency: `rpt_valid` at edge N, then PUSH at N+1. `cmd_valid`=1 after edge N+1.
- Reject: `err_count` updates after edge N+1.
- Pop: head advances on the same edge where `cmd_valid && cmd_ready` is sampled. `fifo_count` updates on that edge.
- Block is ready for a new frame 3 cycles after the previous pulse. The decoder's frame spacing is orders of magnitude larger.

## Configuration
- `IR_REPEAT_EN` defined: repeat handling as described; `cmd_repeat` comes from the FIFO entry.
- Not defined:
  - `rpt_valid` is ignored, and `last_ok` and the last-command register are not built.
  - `cmd_repeat` is tied to 0.
  - FIFO entries omit the repeat bit.
  - All other behaviour is identical.

## Test plan
- Reset, then `frame_data`=32'hF708FF00 pulse with `cmd_ready`=1 -> `cmd_valid` 3 cycles later with `cmd_addr`=8'h00, `cmd_code`=8'h08, `cmd_repeat`=0. `fifo_count` returns to 0 after the pop.
- `frame_data`=32'hF608FF00 (bad cmd complement) -> no `cmd_valid`, `err_count`=1. With `ADDR_FILTER`=1 and `ADDR_MATCH`=8'h10, a valid frame for addr 8'h00 -> dropped, `err_count`=2.
- `cmd_ready`=0, five valid frames with cmds 8'h01..8'h05 -> `fifo_count`=4 and `overflow`=1. Then `cmd_ready`=1 -> pops 01,02,03,04 in order, then `cmd_valid`=0.
- FIFO full and `cmd_ready`=1 during a PUSH cycle -> push accepted, `overflow` stays 0, `fifo_count` stays 4.
- `IR_REPEAT_EN`: valid frame with cmd 8'h45, then two `rpt_valid` pulses -> three entries (45/rep0, 45/rep1, 45/rep1). A `rpt_valid` after reset or after a rejected frame -> no entry.
- Assert `reset` for one cycle while 3 entries are queued and the FSM is in CHECK -> all outputs at reset values next cycle, and the in-flight frame is never delivered.

Source files
------------

// File: rtl/ir_cmd_scheduler.sv
// NEC command scheduler: validates decoded frames, queues accepted commands in a FIFO
// and re-issues repeats as flagged copies. Repeat handling is built only when IR_REPEAT_EN is defined.
module ir_cmd_scheduler #(
    parameter int         DEPTH       = 4,
    parameter bit         ADDR_FILTER = 1'b0,
    parameter logic [7:0] ADDR_MATCH  = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            frame_data,
    input  logic                   frame_valid,
    input  logic                   rpt_valid,
    input  logic                   cmd_ready,
    output logic                   cmd_valid,
    output logic [7:0]             cmd_addr,
    output logic [7:0]             cmd_code,
    output logic                   cmd_repeat,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             err_count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef IR_REPEAT_EN
    localparam int EW = 17;
`else
    localparam int EW = 16;
`endif
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_PUSH  = 2'd2;

    // Both complement bytes must match, and the address must match when filtering.
    function automatic logic frame_ok(input logic [31:0] f);
        return (f[7:0] == ~f[15:8]) && (f[23:16] == ~f[31:24]) &&
               (!ADDR_FILTER || (f[7:0] == ADDR_MATCH));
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [31:0]   cap_r;
    logic [EW-1:0] ent_r;
    logic [EW-1:0] check_ent_s;
    logic [EW-1:0] rpt_ent_s;
    logic [EW-1:0] head_s;
    logic [EW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [7:0]    err_r;
    logic          ovf_r;
    logic          pop_s;
    logic          push_s;
    logic          check_ok_s;
    logic          reject_s;
    logic          busy_drop_s;
    logic          rpt_take_s;
    logic [1:0]    err_inc_s;
    logic [8:0]    err_sum_s;

`ifdef IR_REPEAT_EN
    logic [15:0]   last_r;
    logic          last_ok_r;

    assign rpt_take_s  = rpt_valid && last_ok_r;
    assign check_ent_s = {1'b0, cap_r[7:0], cap_r[23:16]};
    assign rpt_ent_s   = {1'b1, last_r};
    assign cmd_repeat  = head_s[16];

    // Last accepted command, replayed on repeat events
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r    <= 16'h0000;
            last_ok_r <= 1'b0;
        end else if (state_r == ST_CHECK) begin
            last_ok_r <= check_ok_s;
            if (check_ok_s) begin
                last_r <= {cap_r[7:0], cap_r[23:16]};
            end
        end
    end
`else
    logic unused_rpt_s;

    assign unused_rpt_s = rpt_valid;
    assign rpt_take_s   = 1'b0;
    assign check_ent_s  = {cap_r[7:0], cap_r[23:16]};
    assign rpt_ent_s    = {EW{1'b0}};
    assign cmd_repeat   = 1'b0;
`endif

    // Handshake, error accounting and next-state decode
    always_comb begin
        pop_s       = (count_r != {CW{1'b0}}) && cmd_ready;
        push_s      = (state_r == ST_PUSH) && ((count_r != CW'(DEPTH)) || pop_s);
        check_ok_s  = frame_ok(cap_r);
        reject_s    = (state_r == ST_CHECK) && !check_ok_s;
        busy_drop_s = frame_valid && (state_r != ST_IDLE);
        err_inc_s   = {1'b0, busy_drop_s} + {1'b0, reject_s};
        err_sum_s   = {1'b0, err_r} + {7'b0000000, err_inc_s};
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (frame_valid) begin
                    state_nxt_s = ST_CHECK;
                end else if (rpt_take_s) begin
                    state_nxt_s = ST_PUSH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (check_ok_s) begin
                    state_nxt_s = ST_PUSH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PUSH: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control FSM, capture/entry staging, error counter and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cap_r   <= 32'h0000_0000;
            ent_r   <= {EW{1'b0}};
            err_r   <= 8'h00;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && frame_valid) begin
                cap_r <= frame_data;
            end
            if (state_r == ST_CHECK) begin
                ent_r <= check_ent_s;
            end else if ((state_r == ST_IDLE) && !frame_valid && rpt_take_s) begin
                ent_r <= rpt_ent_s;
            end
            if ((state_r == ST_PUSH) && !push_s) begin
                ovf_r <= 1'b1;
            end
            err_r <= err_sum_s[8] ? 8'hFF : err_sum_s[7:0];
        end
    end

    // Circular command FIFO; storage is cleared so head outputs read zero after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= ent_r;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_s     = mem_r[rd_ptr_r];
    assign cmd_valid  = (count_r != {CW{1'b0}});
    assign cmd_addr   = head_s[15:8];
    assign cmd_code   = head_s[7:0];
    assign fifo_count = count_r;
    assign err_count  = err_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Bench for ir_cmd_scheduler: directed scenarios plus random traffic against a
// queue-style reference model; one unfiltered and one address-filtered instance.
module tb_ir_cmd_scheduler;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef IR_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic          clk         = 1'b0;
    logic          reset       = 1'b1;
    logic          frame_valid = 1'b0;
    logic          rpt_valid   = 1'b0;
    logic          cmd_ready   = 1'b0;
    logic [31:0]   frame_data  = 32'h0;
    logic [1:0]    ov;
    logic [1:0]    orep;
    logic [1:0]    oovf;
    logic [7:0]    oa   [2];
    logic [7:0]    oc   [2];
    logic [7:0]    oerr [2];
    logic [CW-1:0] ocnt [2];

    ir_cmd_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid),
        .rpt_valid(rpt_valid), .cmd_ready(cmd_ready), .cmd_valid(ov[0]), .cmd_addr(oa[0]),
        .cmd_code(oc[0]), .cmd_repeat(orep[0]), .fifo_count(ocnt[0]), .err_count(oerr[0]),
        .overflow(oovf[0])
    );

    ir_cmd_scheduler #(.DEPTH(DEPTH), .ADDR_FILTER(1'b1), .ADDR_MATCH(8'h10)) dut_f (
        .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid),
        .rpt_valid(rpt_valid), .cmd_ready(cmd_ready), .cmd_valid(ov[1]), .cmd_addr(oa[1]),
        .cmd_code(oc[1]), .cmd_repeat(orep[1]), .fifo_count(ocnt[1]), .err_count(oerr[1]),
        .overflow(oovf[1])
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: entries are {rep, addr, cmd}; events are scheduled by edge index
    int          fn      [2];
    logic [16:0] fq      [2][DEPTH];
    int          err_m   [2];
    bit          ovf_m   [2];
    bit          lok_m   [2];
    logic [15:0] last_m  [2];
    int          free_at [2];
    bit          cp      [2];
    int          cat     [2];
    logic [31:0] cd      [2];
    bit          pp      [2];
    int          pat     [2];
    logic [16:0] pe      [2];

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    function automatic bit frame_pass(input int i, input logic [31:0] f);
        return (f[7:0] == ~f[15:8]) && (f[23:16] == ~f[31:24]) && (i == 0 || f[7:0] == 8'h10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            fn[i] = 0; err_m[i] = 0; ovf_m[i] = 1'b0; lok_m[i] = 1'b0; last_m[i] = 16'h0;
            free_at[i] = 0; cp[i] = 1'b0; pp[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input int e, input logic fv, input logic [31:0] fd,
                              input logic rv, input logic rdy);
        bit          pop;
        bit          push;
        logic [16:0] pent;
        int          inc;
        pop  = (fn[i] > 0) && rdy;
        push = 1'b0;
        pent = 17'h0;
        inc  = 0;
        if (pp[i] && pat[i] == e) begin
            pp[i] = 1'b0;
            if (fn[i] < DEPTH || pop) begin
                push = 1'b1;
                pent = pe[i];
            end else begin
                ovf_m[i] = 1'b1;
            end
        end
        if (cp[i] && cat[i] == e) begin
            cp[i] = 1'b0;
            if (frame_pass(i, cd[i])) begin
                lok_m[i]  = 1'b1;
                last_m[i] = {cd[i][7:0], cd[i][23:16]};
                pp[i] = 1'b1; pat[i] = e + 1; pe[i] = {1'b0, last_m[i]};
            end else begin
                inc++;
                lok_m[i] = 1'b0;
            end
        end
        if (e >= free_at[i]) begin
            if (fv) begin
                cp[i] = 1'b1; cat[i] = e + 1; cd[i] = fd;
                free_at[i] = frame_pass(i, fd) ? e + 3 : e + 2;
            end else if (REP && rv && lok_m[i]) begin
                pp[i] = 1'b1; pat[i] = e + 1; pe[i] = {1'b1, last_m[i]};
                free_at[i] = e + 2;
            end
        end else if (fv) begin
            inc++;
        end
        if (pop) begin
            for (int k = 0; k < DEPTH - 1; k++) fq[i][k] = fq[i][k+1];
            fn[i]--;
        end
        if (push) begin
            fq[i][fn[i]] = pent;
            fn[i]++;
        end
        err_m[i] = (err_m[i] + inc > 255) ? 255 : err_m[i] + inc;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("valid%0d", i), ov[i], fn[i] > 0);
            chk($sformatf("count%0d", i), ocnt[i], fn[i]);
            chk($sformatf("err%0d", i), oerr[i], err_m[i]);
            chk($sformatf("ovf%0d", i), oovf[i], ovf_m[i]);
            if (fn[i] > 0) begin
                chk($sformatf("addr%0d", i), oa[i], fq[i][0][15:8]);
                chk($sformatf("code%0d", i), oc[i], fq[i][0][7:0]);
                chk($sformatf("rep%0d", i), orep[i], fq[i][0][16]);
            end
        end
    endtask

    task automatic cycle(input logic fv, input logic [31:0] fd, input logic rv,
                         input logic rdy, input logic rst);
        @(negedge clk);
        frame_valid = fv; frame_data = fd; rpt_valid = rv; cmd_ready = rdy; reset = rst;
        @(posedge clk);
        if (rst) model_reset();
        else for (int i = 0; i < 2; i++) model_step(i, cyc, fv, fd, rv, rdy);
        cyc++;
        #1 compare_all();
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) cycle(1'b0, 32'h0, 1'b0, rdy, 1'b0);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] c, input logic rdy);
        cycle(1'b1, mk(a, c), 1'b0, rdy, 1'b0);
        idle(2, rdy);
    endtask

    initial begin
        logic [31:0] f;
        logic [31:0] one;
        logic [7:0]  a;
        one = 32'h1;
        model_reset();
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", ov[0], 1'b0);
        chk("rst_addr", oa[0], 8'h00);
        chk("rst_cnt", ocnt[0], 3'd0);

        // Basic frame: valid three edges after the pulse, then popped
        send(8'h00, 8'h08, 1'b1);
        chk("lat_valid", ov[0], 1'b1);
        chk("lat_addr", oa[0], 8'h00);
        chk("lat_code", oc[0], 8'h08);
        chk("lat_rep", orep[0], 1'b0);
        idle(1, 1'b1);
        chk("pop_cnt", ocnt[0], 3'd0);

        // Bad complement, and address filtering on the second instance
        cycle(1'b1, 32'hF608FF00, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("bad_err", oerr[0], 8'd1);
        chk("filt_err", oerr[1], 8'd2);

        // Overflow with consumer stalled, then in-order drain
        for (int k = 1; k <= 5; k++) send(8'h00, 8'(k), 1'b0);
        chk("full_cnt", ocnt[0], 3'd4);
        chk("full_ovf", oovf[0], 1'b1);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_code", oc[0], 8'(k));
            idle(1, 1'b1);
        end
        chk("drain_empty", ov[0], 1'b0);

        // Push into a full FIFO while a pop happens on the same edge
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) send(8'h00, 8'(k + 16), 1'b0);
        cycle(1'b1, mk(8'h00, 8'h2A), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("pp_cnt", ocnt[0], 3'd4);
        chk("pp_ovf", oovf[0], 1'b0);
        idle(5, 1'b1);

        // Repeat events: none after reset, two copies after a good frame, none after a reject
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("rpt_rst_cnt", ocnt[0], 3'd0);
        send(8'h00, 8'h45, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
`ifdef IR_REPEAT_EN
        chk("rpt_cnt", ocnt[0], 3'd3);
        chk("rpt0_rep", orep[0], 1'b0);
        idle(1, 1'b1);
        chk("rpt1_code", oc[0], 8'h45);
        chk("rpt1_rep", orep[0], 1'b1);
        idle(1, 1'b1);
        chk("rpt2_rep", orep[0], 1'b1);
`else
        chk("rpt_cnt", ocnt[0], 3'd1);
`endif
        idle(2, 1'b1);
        cycle(1'b1, 32'hF608FF00, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("rpt_rej_cnt", ocnt[0], 3'd0);

        // Reset while entries are queued and a frame sits in CHECK
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) send(8'h00, 8'(k + 8'h60), 1'b0);
        cycle(1'b1, mk(8'h00, 8'h77), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("mid_valid", ov[0], 1'b0);
        chk("mid_cnt", ocnt[0], 3'd0);
        chk("mid_addr", oa[0], 8'h00);
        chk("mid_code", oc[0], 8'h00);
        chk("mid_rep", orep[0], 1'b0);
        chk("mid_err", oerr[0], 8'h00);
        chk("mid_ovf", oovf[0], 1'b0);
        idle(4, 1'b1);
        chk("mid_lost", ov[0], 1'b0);

        // Error counter saturation
        repeat (260) begin
            cycle(1'b1, 32'hF608FF00, 1'b0, 1'b1, 1'b0);
            idle(1, 1'b1);
        end
        chk("sat_err0", oerr[0], 8'hFF);
        chk("sat_err1", oerr[1], 8'hFF);

        // Random traffic including collisions, busy drops and occasional resets
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (4000) begin
            case ($urandom_range(0, 3))
                0:       a = 8'h00;
                1:       a = 8'h10;
                default: a = 8'($urandom);
            endcase
            f = mk(a, 8'($urandom));
            if ($urandom_range(0, 3) == 0) f = f ^ (one << $urandom_range(0, 31));
            cycle(($urandom_range(0, 3) == 0), f, ($urandom_range(0, 4) == 0),
                  1'($urandom), ($urandom_range(0, 499) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
